// File: rtl/pong_pkg.sv
// Shared definitions for the pong game blocks: FSM encoding, serve directions, screen size.
package pong_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SERVE     = 3'd1;
  localparam logic [2:0] ST_PLAY      = 3'd2;
  localparam logic [2:0] ST_PAUSE     = 3'd3;
  localparam logic [2:0] ST_POINT     = 3'd4;
  localparam logic [2:0] ST_GAME_OVER = 3'd5;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

endpackage

// File: rtl/pong_match_ctrl_frame_timer.sv
// Loadable 8-bit frame down-counter used to time the serve countdown and the point freeze.
// expired fires on the frame tick that arrives while the count already sits at zero.
module frame_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       tick,
  output logic       expired
);

  logic [7:0] count;

  // Load takes priority; otherwise count down one step per tick and stop at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 8'd0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != 8'd0)) begin
      count <= count - 8'd1;
    end
  end

  assign expired = tick && (count == 8'd0);

endmodule

// File: rtl/pong_match_ctrl.sv
// Match sequencer for pong: serve countdown, play, point freeze, pause and game over.
// Keeps both scores, chooses the serve direction and enables the second ball on long rallies.
module pong_match_ctrl #(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int BALL2_RALLY  = 5,
  parameter int SCORE_W      = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               pause,
  input  logic               miss_left,
  input  logic               miss_right,
  input  logic               hit,
  output logic               round_reset,
  output logic               play_en,
  output logic               serve_dir,
  output logic               ball2_en,
  output logic [SCORE_W-1:0] score_left,
  output logic [SCORE_W-1:0] score_right,
  output logic               game_over,
  output logic               winner,
  output logic [2:0]         state_o
);

  import pong_pkg::*;

  localparam int RALLY_W = $clog2(BALL2_RALLY + 1);
  localparam logic [RALLY_W-1:0] RALLY_MAX  = RALLY_W'(BALL2_RALLY);
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
  localparam logic [7:0]         SERVE_LOAD = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0]         POINT_LOAD = 8'(POINT_FRAMES - 1);

  logic [2:0]         state;
  logic [2:0]         state_next;
  logic [RALLY_W-1:0] rally_cnt;
  logic               timer_load;
  logic [7:0]         timer_val;
  logic               timer_tick;
  logic               timer_expired;
  logic               any_miss;
  logic               win_reached;
  logic               start_match;

  assign any_miss    = miss_left || miss_right;
  assign win_reached = (score_left == WIN_VAL) || (score_right == WIN_VAL);
  assign start_match = start && ((state == ST_IDLE) || (state == ST_GAME_OVER));

  // The timer only advances while a countdown is actually running.
  assign timer_tick = frame_tick && ((state == ST_SERVE) || (state == ST_POINT));

  frame_timer u_frame_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .tick     (timer_tick),
    .expired  (timer_expired)
  );

  // Next-state decode and timer reload requests for each phase of the match.
  always_comb begin
    state_next = state;
    timer_load = 1'b0;
    timer_val  = SERVE_LOAD;
    case (state)
      ST_IDLE, ST_GAME_OVER: begin
        if (start) begin
          state_next = ST_SERVE;
          timer_load = 1'b1;
        end
      end
      ST_SERVE: begin
        if (timer_expired) begin
          state_next = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (any_miss) begin
          state_next = ST_POINT;
          timer_load = 1'b1;
          timer_val  = POINT_LOAD;
        end else if (pause) begin
          state_next = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (pause) begin
          state_next = ST_PLAY;
        end
      end
      ST_POINT: begin
        if (timer_expired) begin
          if (win_reached) begin
            state_next = ST_GAME_OVER;
          end else begin
            state_next = ST_SERVE;
            timer_load = 1'b1;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Scores and serve direction: cleared on a new match, updated only by a single-sided miss in play.
  always_ff @(posedge clk) begin
    if (reset) begin
      score_left  <= '0;
      score_right <= '0;
      serve_dir   <= DIR_LEFT;
    end else if (start_match) begin
      score_left  <= '0;
      score_right <= '0;
    end else if ((state == ST_PLAY) && miss_left && !miss_right) begin
      if (score_right != WIN_VAL) begin
        score_right <= score_right + SCORE_W'(1);
      end
      serve_dir <= DIR_LEFT;
    end else if ((state == ST_PLAY) && miss_right && !miss_left) begin
      if (score_left != WIN_VAL) begin
        score_left <= score_left + SCORE_W'(1);
      end
      serve_dir <= DIR_RIGHT;
    end
  end

  // Rally counter: saturating hit count within one rally, cleared by any miss or a new match.
  always_ff @(posedge clk) begin
    if (reset) begin
      rally_cnt <= '0;
    end else if (start_match) begin
      rally_cnt <= '0;
    end else if (state == ST_PLAY) begin
      if (any_miss) begin
        rally_cnt <= '0;
      end else if (hit && (rally_cnt != RALLY_MAX)) begin
        rally_cnt <= rally_cnt + RALLY_W'(1);
      end
    end
  end

  assign round_reset = (state == ST_IDLE) || (state == ST_SERVE);
  assign play_en     = (state == ST_PLAY);
  assign game_over   = (state == ST_GAME_OVER);
  assign winner      = game_over && (score_left == WIN_VAL);
  assign ball2_en    = (rally_cnt == RALLY_MAX);
  assign state_o     = state;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed self-checking bench for pong_match_ctrl with default parameters.
module tb_pong_match_ctrl;

  logic       clk;
  logic       reset;
  logic       frame_tick;
  logic       start;
  logic       pause;
  logic       miss_left;
  logic       miss_right;
  logic       hit;
  logic       round_reset;
  logic       play_en;
  logic       serve_dir;
  logic       ball2_en;
  logic [3:0] score_left;
  logic [3:0] score_right;
  logic       game_over;
  logic       winner;
  logic [2:0] state_o;

  int total;
  int bad;

  pong_match_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .start       (start),
    .pause       (pause),
    .miss_left   (miss_left),
    .miss_right  (miss_right),
    .hit         (hit),
    .round_reset (round_reset),
    .play_en     (play_en),
    .serve_dir   (serve_dir),
    .ball2_en    (ball2_en),
    .score_left  (score_left),
    .score_right (score_right),
    .game_over   (game_over),
    .winner      (winner),
    .state_o     (state_o)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock and land 1 ns after the edge so outputs are settled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Apply n consecutive frame ticks.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
    end
    frame_tick = 1'b0;
  endtask

  // Pulse the miss inputs for one cycle.
  task automatic pulse_miss(input logic ml, input logic mr);
    miss_left  = ml;
    miss_right = mr;
    step();
    miss_left  = 1'b0;
    miss_right = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    total++; if (state_o !== 3'd0) begin bad++; $display("[TB] FAIL reset_state got=%0d want=0", state_o); end
    total++; if (round_reset !== 1'b1) begin bad++; $display("[TB] FAIL reset_round_reset got=%0b want=1", round_reset); end
    total++; if (play_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_play_en got=%0b want=0", play_en); end
    total++; if (serve_dir !== 1'b1) begin bad++; $display("[TB] FAIL reset_serve_dir got=%0b want=1", serve_dir); end
    total++; if (ball2_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_ball2_en got=%0b want=0", ball2_en); end
    total++; if ({score_left, score_right} !== 8'h00) begin bad++; $display("[TB] FAIL reset_scores got=%0d/%0d want=0/0", score_left, score_right); end
    total++; if ({game_over, winner} !== 2'b00) begin bad++; $display("[TB] FAIL reset_game_over got=%0b%0b want=00", game_over, winner); end
  endtask

  task automatic test_serve();
    pulse_start();
    total++; if (state_o !== 3'd1) begin bad++; $display("[TB] FAIL serve_enter got=%0d want=1", state_o); end
    total++; if (round_reset !== 1'b1) begin bad++; $display("[TB] FAIL serve_round_reset got=%0b want=1", round_reset); end
    ticks(59);
    total++; if (state_o !== 3'd1 || play_en !== 1'b0) begin bad++; $display("[TB] FAIL serve_59 got state=%0d play_en=%0b want 1/0", state_o, play_en); end
    ticks(1);
    total++; if (state_o !== 3'd2) begin bad++; $display("[TB] FAIL serve_60 got=%0d want=2", state_o); end
    total++; if (play_en !== 1'b1 || round_reset !== 1'b0) begin bad++; $display("[TB] FAIL play_outputs got play_en=%0b round_reset=%0b want 1/0", play_en, round_reset); end
  endtask

  task automatic test_point();
    pulse_miss(1'b0, 1'b1);
    total++; if (score_left !== 4'd1 || score_right !== 4'd0) begin bad++; $display("[TB] FAIL point_score got=%0d/%0d want=1/0", score_left, score_right); end
    total++; if (serve_dir !== 1'b0) begin bad++; $display("[TB] FAIL point_serve_dir got=%0b want=0", serve_dir); end
    total++; if (state_o !== 3'd4 || play_en !== 1'b0 || round_reset !== 1'b0) begin bad++; $display("[TB] FAIL point_state got=%0d play_en=%0b rr=%0b want 4/0/0", state_o, play_en, round_reset); end
    start = 1'b1;
    step();
    start = 1'b0;
    total++; if (state_o !== 3'd4) begin bad++; $display("[TB] FAIL point_start_ignored got=%0d want=4", state_o); end
    ticks(89);
    total++; if (state_o !== 3'd4) begin bad++; $display("[TB] FAIL point_89 got=%0d want=4", state_o); end
    ticks(1);
    total++; if (state_o !== 3'd1 || round_reset !== 1'b1) begin bad++; $display("[TB] FAIL point_expiry got=%0d rr=%0b want 1/1", state_o, round_reset); end
    ticks(60);
    total++; if (state_o !== 3'd2) begin bad++; $display("[TB] FAIL point_back_play got=%0d want=2", state_o); end
  endtask

  task automatic test_ball2();
    for (int i = 0; i < 4; i++) begin
      hit = 1'b1;
      step();
      hit = 1'b0;
      step();
    end
    total++; if (ball2_en !== 1'b0) begin bad++; $display("[TB] FAIL ball2_after4 got=%0b want=0", ball2_en); end
    hit = 1'b1;
    step();
    hit = 1'b0;
    total++; if (ball2_en !== 1'b1) begin bad++; $display("[TB] FAIL ball2_after5 got=%0b want=1", ball2_en); end
    hit = 1'b1;
    step();
    hit = 1'b0;
    total++; if (ball2_en !== 1'b1) begin bad++; $display("[TB] FAIL ball2_saturate got=%0b want=1", ball2_en); end
    pulse_miss(1'b1, 1'b0);
    total++; if (ball2_en !== 1'b0) begin bad++; $display("[TB] FAIL ball2_miss_clear got=%0b want=0", ball2_en); end
    total++; if (score_right !== 4'd1 || score_left !== 4'd1) begin bad++; $display("[TB] FAIL ball2_score got=%0d/%0d want=1/1", score_left, score_right); end
    total++; if (serve_dir !== 1'b1 || state_o !== 3'd4) begin bad++; $display("[TB] FAIL ball2_dir_state got dir=%0b state=%0d want 1/4", serve_dir, state_o); end
    ticks(150);
    total++; if (state_o !== 3'd2 || ball2_en !== 1'b0) begin bad++; $display("[TB] FAIL ball2_next_rally got state=%0d b2=%0b want 2/0", state_o, ball2_en); end
  endtask

  task automatic test_double_miss();
    pulse_miss(1'b1, 1'b1);
    total++; if (score_left !== 4'd1 || score_right !== 4'd1) begin bad++; $display("[TB] FAIL dbl_scores got=%0d/%0d want=1/1", score_left, score_right); end
    total++; if (serve_dir !== 1'b1) begin bad++; $display("[TB] FAIL dbl_serve_dir got=%0b want=1", serve_dir); end
    total++; if (state_o !== 3'd4) begin bad++; $display("[TB] FAIL dbl_state got=%0d want=4", state_o); end
    ticks(150);
  endtask

  task automatic test_win();
    for (int i = 0; i < 5; i++) begin
      pulse_miss(1'b0, 1'b1);
      ticks(150);
    end
    total++; if (score_left !== 4'd6 || state_o !== 3'd2) begin bad++; $display("[TB] FAIL win_pre got score=%0d state=%0d want 6/2", score_left, state_o); end
    pulse_miss(1'b0, 1'b1);
    total++; if (score_left !== 4'd7 || state_o !== 3'd4) begin bad++; $display("[TB] FAIL win_point got score=%0d state=%0d want 7/4", score_left, state_o); end
    total++; if (game_over !== 1'b0) begin bad++; $display("[TB] FAIL win_not_yet got=%0b want=0", game_over); end
    ticks(90);
    total++; if (state_o !== 3'd5 || game_over !== 1'b1) begin bad++; $display("[TB] FAIL win_game_over got state=%0d go=%0b want 5/1", state_o, game_over); end
    total++; if (winner !== 1'b1) begin bad++; $display("[TB] FAIL win_winner got=%0b want=1", winner); end
    total++; if (score_left !== 4'd7 || score_right !== 4'd1) begin bad++; $display("[TB] FAIL win_held got=%0d/%0d want=7/1", score_left, score_right); end
    pulse_start();
    total++; if (state_o !== 3'd1 || game_over !== 1'b0) begin bad++; $display("[TB] FAIL restart got state=%0d go=%0b want 1/0", state_o, game_over); end
    total++; if (score_left !== 4'd0 || score_right !== 4'd0) begin bad++; $display("[TB] FAIL restart_scores got=%0d/%0d want=0/0", score_left, score_right); end
    ticks(60);
  endtask

  task automatic test_pause_reset();
    pause = 1'b1;
    step();
    pause = 1'b0;
    total++; if (state_o !== 3'd3 || play_en !== 1'b0 || round_reset !== 1'b0) begin bad++; $display("[TB] FAIL pause_enter got state=%0d pe=%0b rr=%0b want 3/0/0", state_o, play_en, round_reset); end
    hit = 1'b1;
    pulse_miss(1'b1, 1'b0);
    hit = 1'b0;
    total++; if (score_right !== 4'd0 || state_o !== 3'd3) begin bad++; $display("[TB] FAIL pause_miss got score=%0d state=%0d want 0/3", score_right, state_o); end
    pause = 1'b1;
    step();
    pause = 1'b0;
    total++; if (state_o !== 3'd2 || play_en !== 1'b1) begin bad++; $display("[TB] FAIL pause_exit got state=%0d pe=%0b want 2/1", state_o, play_en); end
    pause = 1'b1;
    pulse_miss(1'b1, 1'b0);
    pause = 1'b0;
    total++; if (state_o !== 3'd4 || score_right !== 4'd1) begin bad++; $display("[TB] FAIL miss_beats_pause got state=%0d score=%0d want 4/1", state_o, score_right); end
    ticks(10);
    reset = 1'b1;
    frame_tick = 1'b1;
    step();
    reset = 1'b0;
    frame_tick = 1'b0;
    total++; if (state_o !== 3'd0 || round_reset !== 1'b1 || play_en !== 1'b0) begin bad++; $display("[TB] FAIL midreset_state got state=%0d rr=%0b pe=%0b want 0/1/0", state_o, round_reset, play_en); end
    total++; if (score_right !== 4'd0 || serve_dir !== 1'b1) begin bad++; $display("[TB] FAIL midreset_regs got score=%0d dir=%0b want 0/1", score_right, serve_dir); end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    reset      = 1'b0;
    frame_tick = 1'b0;
    start      = 1'b0;
    pause      = 1'b0;
    miss_left  = 1'b0;
    miss_right = 1'b0;
    hit        = 1'b0;
    test_reset();
    test_serve();
    test_point();
    test_ball2();
    test_double_miss();
    test_win();
    test_pause_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
